// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and byte width shared by the SPI transaction sequencer
package spi_pkg;
  localparam int SPI_BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, SETUP, LOAD, START, WAITB, XFER, PUSH, HOLD} state_e;
endpackage

// File: rtl/spi_gap_cnt.sv
// spi_gap_cnt: loadable down-counter with done flag, shared by chip-select gaps and the watchdog
module spi_gap_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  assign done = cnt_q == '0;
  // load on request, otherwise count down and park at zero
  always_comb cnt_d = ld ? ld_val : (done ? cnt_q : cnt_q - 1'b1);
  // counter register
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: SPI transaction sequencer with CS framing; SPI_XFER_SEQ_TMO_EN adds watchdog and err output
module spi_xfer_seq
  import spi_pkg::*;
#(
  parameter int NSLAVE   = 2,
  parameter int SEL_W    = (NSLAVE > 1) ? $clog2(NSLAVE) : 1,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TMO_CYC  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SEL_W-1:0]      cmd_slave,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_last,
  output logic [NSLAVE-1:0]     sel,
  output logic                  spi_start,
  output logic [SPI_BYTE_W-1:0] spi_data_in,
  input  logic                  spi_busy,
  input  logic                  spi_new_data,
  input  logic [SPI_BYTE_W-1:0] spi_data_out,
  output logic                  busy
`ifdef SPI_XFER_SEQ_TMO_EN
  , output logic                err
`endif
);
  localparam int CNT_MAX = (TMO_CYC > CS_SETUP && TMO_CYC > CS_HOLD) ? TMO_CYC :
                           (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  state_e                  state_q, state_d;
  logic [NSLAVE-1:0]       sel_q, sel_d;
  logic [LEN_W-1:0]        len_q, len_d, byte_cnt_q, byte_cnt_d;
  logic [SPI_BYTE_W-1:0]   spi_data_in_q, spi_data_in_d, rx_data_q, rx_data_d;
  logic                    rx_last_q, rx_last_d, gap_ld, gap_done, last;
  logic [CNT_W-1:0]        gap_val;
`ifdef SPI_XFER_SEQ_TMO_EN
  logic                    err_q, err_d;
  assign err = err_q;
`endif
  assign last        = byte_cnt_q == len_q;
  assign cmd_ready   = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign tx_ready    = state_q == LOAD;
  assign spi_start   = state_q == START;
  assign rx_valid    = state_q == PUSH;
  assign sel         = sel_q;
  assign spi_data_in = spi_data_in_q;
  assign rx_data     = rx_data_q;
  assign rx_last     = rx_last_q;
  assign gap_ld      = state_d != state_q;
  assign gap_val     = state_d == SETUP ? CNT_W'(CS_SETUP - 1) :
                       state_d == HOLD  ? CNT_W'(CS_HOLD - 1)  : CNT_W'(TMO_CYC - 1);
  spi_gap_cnt #(.W(CNT_W)) u_gap (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (gap_ld),
    .ld_val(gap_val),
    .done  (gap_done)
  );
  // next-state and datapath: the compare with len precedes the increment so all-ones len never wraps
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    len_d         = len_q;
    byte_cnt_d    = byte_cnt_q;
    spi_data_in_d = spi_data_in_q;
    rx_data_d     = rx_data_q;
    rx_last_d     = rx_last_q;
`ifdef SPI_XFER_SEQ_TMO_EN
    err_d         = 1'b0;
`endif
    case (state_q)
      IDLE:
        if (cmd_valid) begin
          if (32'(cmd_slave) < NSLAVE) begin
            sel_d   = NSLAVE'(1) << cmd_slave;
            len_d   = cmd_len;
            state_d = SETUP;
          end
`ifdef SPI_XFER_SEQ_TMO_EN
          else err_d = 1'b1;
`endif
        end
      SETUP: if (gap_done) state_d = LOAD;
      LOAD:
        if (tx_valid) begin
          spi_data_in_d = tx_data;
          state_d       = START;
        end
      START: state_d = WAITB;
      WAITB:
        if (spi_busy) state_d = XFER;
`ifdef SPI_XFER_SEQ_TMO_EN
        else if (gap_done) begin
          state_d = HOLD;
          err_d   = 1'b1;
        end
`endif
      XFER:
        if (spi_new_data) begin
          rx_data_d = spi_data_out;
          rx_last_d = last;
          state_d   = PUSH;
        end
`ifdef SPI_XFER_SEQ_TMO_EN
        else if (gap_done) begin
          state_d = HOLD;
          err_d   = 1'b1;
        end
`endif
      PUSH:
        if (rx_ready) begin
          if (last) state_d = HOLD;
          else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = LOAD;
          end
        end
      HOLD:
        if (gap_done) begin
          sel_d      = '0;
          byte_cnt_d = '0;
          state_d    = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      len_q         <= '0;
      byte_cnt_q    <= '0;
      spi_data_in_q <= '0;
      rx_data_q     <= '0;
      rx_last_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      len_q         <= len_d;
      byte_cnt_q    <= byte_cnt_d;
      spi_data_in_q <= spi_data_in_d;
      rx_data_q     <= rx_data_d;
      rx_last_q     <= rx_last_d;
    end
`ifdef SPI_XFER_SEQ_TMO_EN
  // one-cycle error pulse for timeouts and invalid slave commands
  always_ff @(posedge clk)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
`endif
endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: randomized directed bench with an SPI master/slave loopback model; honours SPI_XFER_SEQ_TMO_EN
module tb_spi_xfer_seq;
  localparam int NS = 3, SW = 2, LW = 4, CSS = 2, CSH = 2, TMO = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0, rx_last;
  logic [SW-1:0] cmd_slave = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [7:0] tx_data = '0, rx_data, spi_data_in, spi_data_out;
  logic [NS-1:0] sel;
  logic spi_start, spi_busy, spi_new_data, busy;
`ifdef SPI_XFER_SEQ_TMO_EN
  logic err;
`endif
  int n_cmp = 0, n_bad = 0, cyc = 0, rx_seen = 0;
  bit hang = 0, long_busy = 0;
  logic [7:0] start_bytes[$];
  int start_cycs[$];
  logic [7:0] txb[16];

  spi_xfer_seq #(.NSLAVE(NS), .LEN_W(LW), .CS_SETUP(CSS), .CS_HOLD(CSH), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave(cmd_slave),
    .cmd_len(cmd_len), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last), .sel(sel),
    .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_busy(spi_busy),
    .spi_new_data(spi_new_data), .spi_data_out(spi_data_out), .busy(busy)
`ifdef SPI_XFER_SEQ_TMO_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rx_valid) rx_seen <= rx_seen + 1;

  // SPI master + slave model: records each started byte, answers with byte ^ 8'hF0
  initial begin
    logic [7:0] b;
    spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = '0;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        b = spi_data_in;
        start_bytes.push_back(b);
        start_cycs.push_back(cyc);
        if (!hang) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          spi_busy = 1'b1;
          repeat (long_busy ? 30 : $urandom_range(2, 6)) @(negedge clk);
          spi_busy = 1'b0; spi_new_data = 1'b1; spi_data_out = b ^ 8'hF0;
          @(negedge clk);
          spi_new_data = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int s, input int len, input int stall);
    int n0, acc, w, k;
    logic [NS-1:0] es;
    logic [7:0] held;
    es = NS'(1) << s;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_slave = SW'(s); cmd_len = LW'(len); tx_valid = 1'b1; tx_data = txb[0];
    n0 = start_bytes.size();
    @(negedge clk);
    cmd_valid = 1'b0; acc = cyc;
    chk("sel_on_accept", sel, es);
    for (int i = 0; i <= len; i++) begin
      tx_valid = 1'b1; tx_data = txb[i];
      w = 0;
      while (!tx_ready && w < 200) begin @(negedge clk); w++; end
      chk("tx_ready", tx_ready, 1);
      @(negedge clk);
      tx_valid = 1'b0;
      chk("spi_data_in", spi_data_in, txb[i]);
      w = 0;
      while (!rx_valid && w < 200) begin @(negedge clk); w++; end
      chk("rx_valid", rx_valid, 1);
      chk("rx_data", rx_data, txb[i] ^ 8'hF0);
      chk("rx_last", rx_last, i == len);
      chk("sel_held", sel, es);
      if (stall > 0 && i == 0) begin
        held = rx_data;
        repeat (stall) @(negedge clk);
        chk("stall_no_start", start_bytes.size(), n0 + 1);
        chk("stall_rx_data", rx_data, held);
        chk("stall_rx_valid", rx_valid, 1);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    k = 1;
    while (sel != '0 && k < 50) begin @(negedge clk); k++; end
    chk("sel_fall_lat", k, CSH + 1);
    chk("idle_after", cmd_ready, 1);
    chk("start_count", start_bytes.size() - n0, len + 1);
    if (start_cycs.size() > n0) chk("start_lat", start_cycs[n0] - acc, CSS + 1);
    for (int i = 0; i <= len; i++)
      if (n0 + i < start_bytes.size()) chk("start_byte", start_bytes[n0 + i], txb[i]);
  endtask

  initial begin
    int n0, r0, w, k;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_in", spi_data_in, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_last", rx_last, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    txb[0] = 8'hA5;
    run(1, 0, 0);
    txb[0] = 8'h01; txb[1] = 8'h02; txb[2] = 8'h03;
    run(0, 2, 0);
    for (int i = 0; i < 16; i++) txb[i] = 8'($urandom);
    run(2, 1, 20);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_slave = 2'd3; cmd_len = '0;
    n0 = start_bytes.size();
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bad_slave_sel", sel, 0);
    chk("bad_slave_ready", cmd_ready, 1);
    chk("bad_slave_busy", busy, 0);
`ifdef SPI_XFER_SEQ_TMO_EN
    chk("bad_slave_err", err, 1);
`endif
    repeat (10) @(negedge clk);
    chk("bad_slave_nostart", start_bytes.size(), n0);
`ifdef SPI_XFER_SEQ_TMO_EN
    chk("bad_slave_err_pulse", err, 0);
`endif
    for (int i = 0; i < 16; i++) txb[i] = 8'($urandom);
    run($urandom_range(0, 2), 15, 0);
    repeat (6) begin
      for (int i = 0; i < 16; i++) txb[i] = 8'($urandom);
      run($urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(0, 1) * $urandom_range(1, 8));
    end
    long_busy = 1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_slave = '0; cmd_len = '0; tx_valid = 1'b1; tx_data = 8'h3C;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!spi_busy && w < 100) begin @(negedge clk); w++; end
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    r0 = rx_seen;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_sel_drop", sel, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_sel", sel, 0);
    chk("post_rst_start", spi_start, 0);
    chk("post_rst_rx_valid", rx_valid, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    repeat (40) @(negedge clk);
    chk("abort_no_rx", rx_seen, r0);
    chk("abort_idle", busy, 0);
    long_busy = 0;
`ifdef SPI_XFER_SEQ_TMO_EN
    hang = 1;
    r0 = rx_seen;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_slave = 2'd1; cmd_len = '0; tx_valid = 1'b1; tx_data = 8'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!spi_start && w < 100) begin @(negedge clk); w++; end
    tx_valid = 1'b0;
    k = 0;
    while (!err && k < 100) begin @(negedge clk); k++; end
    chk("tmo_err_lat", k, TMO + 1);
    @(negedge clk);
    chk("tmo_err_pulse", err, 0);
    w = 0;
    while (sel != '0 && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    chk("tmo_idle", cmd_ready, 1);
    chk("tmo_no_rx", rx_seen, r0);
    hang = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
